// File: rtl/fabric_config_pkg.sv
// Shared definitions for the fabric configuration path: bitstream constants
// and the UART receiver state encoding used by the bitstream loaders.
package fabric_config_pkg;

    localparam logic [31:0] BITSTREAM_START = 32'hFAB0FAB1;
    localparam int          DESYNC_FLAG     = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first, with a 2-FF input synchronizer.
// Samples each bit at its middle; returns to idle at the mid-stop sample.
module uart_rx_byte
    import fabric_config_pkg::*;
#(
    parameter int ClksPerBit = 87
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o,
    output logic       active_o
);

    localparam int BaudW = $clog2(ClksPerBit);
    localparam logic [BaudW-1:0] BaudHalf = BaudW'(ClksPerBit / 2 - 1);
    localparam logic [BaudW-1:0] BaudFull = BaudW'(ClksPerBit - 1);

    logic              rx_meta_q;
    logic              rx_s_q;
    uart_state_t       state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              byte_valid;
    logic              frame_err;
    logic              baud_zero;

    assign baud_zero = (baud_q == '0);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    baud_d  = BaudHalf;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!baud_zero) begin
                    baud_d = baud_q - 1'b1;
                end else if (rx_s_q) begin
                    // Start bit gone high at mid-bit: treat as line glitch
                    state_d = S_IDLE;
                end else begin
                    baud_d  = BaudFull;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!baud_zero) begin
                    baud_d = baud_q - 1'b1;
                end else begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    baud_d  = BaudFull;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!baud_zero) begin
                    baud_d = baud_q - 1'b1;
                end else begin
                    byte_valid = rx_s_q;
                    frame_err  = !rx_s_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
        end
    end

    assign byte_o        = shreg_q;
    assign byte_valid_o  = byte_valid;
    assign frame_error_o = frame_err;
    assign active_o      = (state_q != S_IDLE);

endmodule

// File: rtl/bitstream_uart_loader.sv
// UART bitstream loader: packs received bytes big-endian into 32-bit words.
// Define BITSTREAM_UART_TIMEOUT_EN to discard stale partial words after idle.
module bitstream_uart_loader
    import fabric_config_pkg::*;
#(
    parameter int ClksPerBit    = 87,
    parameter int TimeoutCycles = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    output logic [31:0] bitstream_data_o,
    output logic        bitstream_valid_o,
    output logic        frame_error_o,
    output logic        busy_o
);

    if (ClksPerBit < 4 || TimeoutCycles < 2) begin : g_bad_cfg
        $error("bitstream_uart_loader: unsupported parameters");
    end

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ferr;
    logic        rx_active;

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    uart_rx_byte #(
        .ClksPerBit(ClksPerBit)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (uart_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_error_o(rx_ferr),
        .active_o     (rx_active)
    );

`ifdef BITSTREAM_UART_TIMEOUT_EN
    localparam int IdleW = $clog2(TimeoutCycles);
    logic [IdleW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = rx_ferr;
        if (rx_ferr) begin
            byte_cnt_d = 2'd0;
        end else if (rx_valid) begin
            unique case (byte_cnt_q)
                2'd0: acc_d[23:16] = rx_byte;
                2'd1: acc_d[15:8]  = rx_byte;
                2'd2: acc_d[7:0]   = rx_byte;
                2'd3: begin
                    data_d  = {acc_q, rx_byte};
                    valid_d = 1'b1;
                end
                default: ;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
`ifdef BITSTREAM_UART_TIMEOUT_EN
        idle_d = idle_q;
        if (rx_active || byte_cnt_q == 2'd0) begin
            idle_d = '0;
        end else if (idle_q == IdleW'(TimeoutCycles - 1)) begin
            // Host gave up mid-word: realign on the next byte
            idle_d     = '0;
            byte_cnt_d = 2'd0;
            acc_d      = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_cnt_q <= 2'd0;
            acc_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef BITSTREAM_UART_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef BITSTREAM_UART_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign bitstream_data_o  = data_q;
    assign bitstream_valid_o = valid_q;
    assign frame_error_o     = ferr_q;
    assign busy_o            = rx_active || (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_bitstream_uart_loader.sv
// Scoreboard bench for bitstream_uart_loader (ClksPerBit=4, TimeoutCycles=64).
module tb_bitstream_uart_loader;

    localparam int Cpb = 4;
    localparam int Tmo = 64;
    // Edge of the stop-bit sample, counted from the edge that starts the frame
    localparam int StopEdge = 3 + Cpb / 2 + 9 * Cpb;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic [31:0] bitstream_data_o;
    logic        bitstream_valid_o;
    logic        frame_error_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   fe_cnt = 0;

    bitstream_uart_loader #(
        .ClksPerBit   (Cpb),
        .TimeoutCycles(Tmo)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .uart_rx_i        (uart_rx_i),
        .bitstream_data_o (bitstream_data_o),
        .bitstream_valid_o(bitstream_valid_o),
        .frame_error_o    (frame_error_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (frame_error_o) fe_cnt++;
            if (bitstream_valid_o) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got %h expected none",
                             bitstream_data_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("word", bitstream_data_o, mon_e.data);
                    chk("latency", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic drive(input logic [9:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            uart_rx_i = fr[i / Cpb];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        drive({1'b1, b, 1'b0}, 10 * Cpb);
    endtask

    task automatic idle(input int n);
        uart_rx_i = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Call just before sending the byte that completes the word
    task automatic expect_word(input logic [31:0] w);
        exp_t e;
        e.data = w;
        e.at   = cyc + StopEdge;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        idle(12);
        chk({name, "_pending"}, sb.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_data"}, bitstream_data_o, 32'h0);
        chk({name, "_valid"}, {31'd0, bitstream_valid_o}, 32'd0);
        chk({name, "_ferr"}, {31'd0, frame_error_o}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        idle(3);
        chk_zero("reset");
        rst_i = 1'b0;
        idle(4);

        send(8'hFA); send(8'hB0); send(8'hFA);
        expect_word(32'hFAB0FAB1);
        send(8'hB1);
        drain("sync");
        chk("sync_busy", {31'd0, busy_o}, 32'd0);
        chk("sync_ferr", fe_cnt, 0);

        uart_rx_i = 1'b0;
        @(posedge clk);
        #1;
        idle(10);
        chk("glitch_busy", {31'd0, busy_o}, 32'd0);
        chk("glitch_ferr", fe_cnt, 0);
        send(8'h12); send(8'h34); send(8'h56);
        expect_word(32'h12345678);
        send(8'h78);
        drain("after_glitch");

        send(8'hAA);
        drive({1'b0, 8'h55, 1'b0}, 10 * Cpb);
        idle(8);
        chk("frame_err_cnt", fe_cnt, 1);
        chk("frame_err_busy", {31'd0, busy_o}, 32'd0);
        send(8'h01); send(8'h02); send(8'h03);
        expect_word(32'h01020304);
        send(8'h04);
        drain("after_ferr");

        send(8'h00); send(8'h01); send(8'h02);
        expect_word(32'h00010203);
        send(8'h03);
        send(8'h04); send(8'h05); send(8'h06);
        expect_word(32'h04050607);
        send(8'h07);
        drain("b2b");
        chk("b2b_ferr", fe_cnt, 1);

        send(8'h11);
        drive({1'b1, 8'h5C, 1'b0}, Cpb + 4 * Cpb + 2);
        rst_i = 1'b1;
        uart_rx_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_zero("midreset");
        idle(4);
        send(8'hDE); send(8'hAD); send(8'hBE);
        expect_word(32'hDEADBEEF);
        send(8'hEF);
        drain("after_reset");

        send(8'h5A); send(8'hC3);
        idle(70);
        send(8'h11);
`ifdef BITSTREAM_UART_TIMEOUT_EN
        send(8'h22); send(8'h33);
        expect_word(32'h11223344);
        send(8'h44);
        drain("timeout");
        chk("timeout_busy", {31'd0, busy_o}, 32'd0);
`else
        expect_word(32'h5AC31122);
        send(8'h22);
        send(8'h33); send(8'h44);
        drain("no_timeout");
        chk("no_timeout_busy", {31'd0, busy_o}, 32'd1);
`endif
        chk("final_ferr", fe_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
